// File: rtl/kronos_mem_arbiter.sv
// Round-robin arbiter merging the Kronos instruction and data ports onto one
// single-ported synchronous SRAM with 1-cycle read latency.
module kronos_mem_arbiter #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic [31:0]       instr_addr,
  input  logic              instr_req,
  output logic [31:0]       instr_data,
  output logic              instr_gnt,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wr_data,
  input  logic [3:0]        data_wr_mask,
  input  logic              data_rd_req,
  input  logic              data_wr_req,
  output logic [31:0]       data_rd_data,
  output logic              data_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_wr_mask,
  input  logic [31:0]       mem_rd_data
);

  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned ADDR_MSB = MEM_AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              data_req;
  logic              winner;
  logic              win_en;
  logic              win_we;
  logic [MEM_AW-1:0] win_addr;

  assign data_req = data_rd_req | data_wr_req;

  // last_owner resets to data so the instruction port wins the first tie
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    winner       = 1'b0;
    win_en       = 1'b0;
    win_we       = 1'b0;
    win_addr     = '0;
    case (state_q)
      IDLE: begin
        if (instr_req || data_req) begin
          winner       = (instr_req && data_req) ? ~last_owner_q : data_req;
          win_en       = 1'b1;
          win_we       = winner & data_wr_req;
          win_addr     = winner ? data_addr[ADDR_MSB:ADDR_LSB]
                                : instr_addr[ADDR_MSB:ADDR_LSB];
          state_d      = RESP;
          owner_d      = winner;
          last_owner_d = winner;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are held off while reset is asserted, even with a request pending
  assign mem_en      = rstz & win_en;
  assign mem_we      = rstz & win_en & win_we;
  assign mem_addr    = win_addr;
  assign mem_wr_data = data_wr_data;
  assign mem_wr_mask = data_wr_mask;

  assign instr_gnt    = (state_q == RESP) & ~owner_q;
  assign data_gnt     = (state_q == RESP) &  owner_q;
  assign instr_data   = mem_rd_data;
  assign data_rd_data = mem_rd_data;

  // Byte-offset and out-of-range address bits are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr[31:MEM_AW+2], instr_addr[1:0],
                              data_addr[31:MEM_AW+2], data_addr[1:0]};

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Randomized scoreboard bench for kronos_mem_arbiter with an SRAM model and a
// transaction-level reference model of the arbitration and memory contents.
module tb_kronos_mem_arbiter;

  localparam int unsigned MEM_AW = 12;
  localparam int unsigned DEPTH  = 1 << MEM_AW;

  logic              clk;
  logic              rstz;
  logic [31:0]       instr_addr;
  logic              instr_req;
  logic [31:0]       instr_data;
  logic              instr_gnt;
  logic [31:0]       data_addr;
  logic [31:0]       data_wr_data;
  logic [3:0]        data_wr_mask;
  logic              data_rd_req;
  logic              data_wr_req;
  logic [31:0]       data_rd_data;
  logic              data_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wr_data;
  logic [3:0]        mem_wr_mask;
  logic [31:0]       mem_rd_data;

  kronos_mem_arbiter #(.MEM_AW(MEM_AW)) dut (
    .clk          (clk),
    .rstz         (rstz),
    .instr_addr   (instr_addr),
    .instr_req    (instr_req),
    .instr_data   (instr_data),
    .instr_gnt    (instr_gnt),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_wr_mask (data_wr_mask),
    .data_rd_req  (data_rd_req),
    .data_wr_req  (data_wr_req),
    .data_rd_data (data_rd_data),
    .data_gnt     (data_gnt),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_mask  (mem_wr_mask),
    .mem_rd_data  (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous, byte-masked write, 1-cycle read latency
  logic [31:0] sram [DEPTH];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wr_mask[b]) sram[mem_addr][8*b +: 8] <= mem_wr_data[8*b +: 8];
      end else begin
        rd_q <= sram[mem_addr];
      end
    end
  end
  assign mem_rd_data = rd_q;

  typedef struct {
    bit          who;   // 0 = instr, 1 = data
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_vec;
  int          n_err;
  bit          chk_en;
  bit          last_m;
  bit          busy_m;
  int          stall;
  logic [31:0] r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[13:2] = 12'($urandom_range(0, 15));
    return a;
  endfunction

  // Reference model: one accepted access per two cycles, ties go to whoever
  // did not win last; tracks memory contents at word/byte level.
  initial begin : model
    exp_t        e;
    logic [11:0] wa;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (busy_m) begin
          busy_m = 1'b0;
          chk("no_strobe_in_resp", 32'(mem_en), 32'd0);
        end else if (instr_req || data_rd_req || data_wr_req) begin
          e.who  = (instr_req && (data_rd_req || data_wr_req)) ? !last_m : !instr_req;
          last_m = e.who;
          busy_m = 1'b1;
          wa     = e.who ? data_addr[13:2] : instr_addr[13:2];
          e.wr   = e.who && data_wr_req;
          e.data = ref_mem[wa];
          chk("strobe_en", 32'(mem_en), 32'd1);
          chk("strobe_addr", 32'(mem_addr), 32'(wa));
          chk("strobe_we", 32'(mem_we), 32'(e.wr));
          if (e.wr) begin
            chk("strobe_mask", 32'(mem_wr_mask), 32'(data_wr_mask));
            chk("strobe_wdata", mem_wr_data, data_wr_data);
            for (int b = 0; b < 4; b++)
              if (data_wr_mask[b]) ref_mem[wa][8*b +: 8] = data_wr_data[8*b +: 8];
          end
          exp_q.push_back(e);
        end else begin
          chk("no_strobe_idle", 32'(mem_en), 32'd0);
        end
      end
    end
  end

  // Monitor: pops one expected response per observed grant
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("gnt_exclusive", 32'(instr_gnt & data_gnt), 32'd0);
        if (instr_gnt || data_gnt) begin
          stall = 0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_gnt: instr_gnt=%0b data_gnt=%0b with nothing pending at %0t",
                     instr_gnt, data_gnt, $time);
          end else begin
            e = exp_q.pop_front();
            chk("gnt_owner", 32'(data_gnt), 32'(e.who));
            if (!e.wr) chk("rd_data", e.who ? data_rd_data : instr_data, e.data);
          end
        end else if (exp_q.size() > 0) begin
          stall++;
          if (stall > 1) begin
            n_vec++;
            n_err++;
            $display("FAIL gnt_timeout: no gnt for pending access (owner %0d) at %0t",
                     exp_q[0].who, $time);
            void'(exp_q.pop_front());
            stall = 0;
          end
        end
      end
    end
  end

  task automatic raise_instr();
    instr_addr = rand_addr();
    instr_req  = 1'b1;
  endtask

  task automatic raise_data();
    int kind;
    kind         = $urandom_range(0, 2);
    data_addr    = rand_addr();
    data_wr_data = $urandom;
    data_wr_mask = 4'($urandom);
    data_rd_req  = (kind != 1);
    data_wr_req  = (kind != 0);
  endtask

  // Random masters: hold until gnt, optionally re-request or drop early
  task automatic rand_phase(input int ncyc, input int raise_pct, input int drop_pct);
    int wi, wd;
    bit gi, gd, free_i, free_d;
    wi = 0;
    wd = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      gi = instr_gnt;
      gd = data_gnt;
      if (instr_req) begin
        wi++;
        if (gi) chk("instr_wait_bound", 32'(wi <= 4), 32'd1);
      end
      if (data_rd_req || data_wr_req) begin
        wd++;
        if (gd) chk("data_wait_bound", 32'(wd <= 4), 32'd1);
      end
      free_i = !instr_req || gi;
      free_d = !(data_rd_req || data_wr_req) || gd;
      @(posedge clk);
      #1;
      if (free_i) begin
        wi = 0;
        if (int'($urandom_range(0, 99)) < raise_pct) raise_instr();
        else instr_req = 1'b0;
      end else if (int'($urandom_range(0, 99)) < drop_pct) begin
        wi = 0;
        instr_req = 1'b0;
      end
      if (free_d) begin
        wd = 0;
        if (int'($urandom_range(0, 99)) < raise_pct) raise_data();
        else begin data_rd_req = 1'b0; data_wr_req = 1'b0; end
      end else if (int'($urandom_range(0, 99)) < drop_pct) begin
        wd = 0;
        data_rd_req = 1'b0;
        data_wr_req = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    instr_req   = 1'b0;
    data_rd_req = 1'b0;
    data_wr_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic xfer(input bit who, input logic [31:0] a, input bit rd, input bit wr,
                      input logic [31:0] wd, input logic [3:0] m, output logic [31:0] rdat);
    bit got;
    @(posedge clk);
    #1;
    if (who) begin
      data_addr = a; data_wr_data = wd; data_wr_mask = m;
      data_rd_req = rd; data_wr_req = wr;
    end else begin
      instr_addr = a; instr_req = 1'b1;
    end
    got  = 1'b0;
    rdat = '0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (who ? data_gnt : instr_gnt) begin
        got  = 1'b1;
        rdat = who ? data_rd_data : instr_data;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout: master %0d addr 0x%08h never granted", who, a);
    end
    @(posedge clk);
    #1;
    instr_req   = 1'b0;
    data_rd_req = 1'b0;
    data_wr_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit got;
    logic [31:0] v;
    n_vec = 0; n_err = 0; stall = 0;
    chk_en = 1'b0; last_m = 1'b1; busy_m = 1'b0;
    rstz = 1'b0;
    instr_addr = '0; instr_req = 1'b0;
    data_addr = '0; data_wr_data = '0; data_wr_mask = '0;
    data_rd_req = 1'b0; data_wr_req = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      sram[i] <= v;
      ref_mem[i] = v;
    end
    sram[4] <= 32'h0000_0013;
    ref_mem[4] = 32'h0000_0013;

    // Strobes must stay low during reset even with a request pending
    instr_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_instr_gnt", 32'(instr_gnt), 32'd0);
    chk("rst_data_gnt", 32'(data_gnt), 32'd0);
    instr_req = 1'b0;
    @(posedge clk);
    #2;
    rstz   = 1'b1;
    chk_en = 1'b1;

    xfer(1'b0, 32'h0000_0010, 1'b1, 1'b0, '0, '0, r);
    chk("first_fetch_data", r, 32'h0000_0013);

    xfer(1'b1, 32'h0000_0104, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011, r);
    xfer(1'b1, 32'h0000_0104, 1'b1, 1'b0, '0, '0, r);
    chk("half_write_low", 32'(r[15:0]), 32'h0000_BEEF);

    // Both masters continuously requesting: strict alternation
    rand_phase(16, 100, 0);

    // Read and write together: single write strobe, one gnt
    xfer(1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h1234_5678, 4'b1111, r);
    xfer(1'b1, 32'h0000_0020, 1'b1, 1'b0, '0, '0, r);
    chk("rdwr_is_write", r, 32'h1234_5678);

    // Request dropped in RESP still gets its gnt, then no strobe
    repeat (2) @(posedge clk);
    #1;
    instr_addr = 32'h0000_0010;
    instr_req  = 1'b1;
    @(posedge clk);
    #1;
    instr_req = 1'b0;
    @(negedge clk);
    chk("drop_resp_gnt", 32'(instr_gnt), 32'd1);
    @(negedge clk);
    chk("drop_next_no_strobe", 32'(mem_en), 32'd0);

    rand_phase(600, 40, 6);

    // Reset asserted in RESP kills the pending gnt
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    instr_addr = 32'h0000_0010;
    instr_req  = 1'b1;
    @(negedge clk);
    chk("rst_resp_strobe", 32'(mem_en), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_resp_gnt_before", 32'(instr_gnt), 32'd1);
    rstz = 1'b0;
    #1;
    chk("rst_resp_gnt_drop", 32'(instr_gnt), 32'd0);
    chk("rst_resp_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("rst_hold_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #2;
    rstz   = 1'b1;
    last_m = 1'b1;
    busy_m = 1'b0;
    exp_q.delete();
    stall  = 0;
    chk_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (instr_gnt) begin
        got = 1'b1;
        chk("reissue_data", instr_data, ref_mem[4]);
      end
    end
    chk("reissue_gnt", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    instr_req = 1'b0;
    repeat (3) @(posedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
- Downstream of the Kronos core.
- Takes the core's instruction port (read-only) and data port (read/write with byte mask), both req/gnt. Merges them onto one single-ported synchronous SRAM with 1-cycle read latency.
- Arbitrates round-robin when both request. Returns grant and read data to the winning master in the response cycle.

Parameters:
- MEM_AW, 12, word-address width of the SRAM (2^MEM_AW 32-bit words).

Ports:
- clk  input  1  core clock
- rstz  input  1  asynchronous active-low reset
- instr_addr  input  32  instruction fetch byte address
- instr_req  input  1  instruction read request, held until instr_gnt
- instr_data  output  32  instruction read data, valid when instr_gnt=1
- instr_gnt  output  1  one-cycle pulse: instruction access complete
- data_addr  input  32  data byte address
- data_wr_data  input  32  store data
- data_wr_mask  input  4  byte enables for store
- data_rd_req  input  1  load request, held until data_gnt
- data_wr_req  input  1  store request, held until data_gnt
- data_rd_data  output  32  load data, valid when data_gnt=1
- data_gnt  output  1  one-cycle pulse: data access complete
- mem_en  output  1  SRAM access strobe
- mem_we  output  1  SRAM write enable, qualified by mem_en
- mem_addr  output  MEM_AW  SRAM word address
- mem_wr_data  output  32  SRAM write data
- mem_wr_mask  output  4  SRAM byte write enables
- mem_rd_data  input  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- State machine has two states, IDLE and RESP, plus a registered owner bit (0=instr, 1=data) and a registered last_owner bit.
- Reset (rstz low, async):
  - state=IDLE, owner=0, last_owner=1 (so instr wins the first tie).
  - instr_gnt=0, data_gnt=0.
  - mem_en=0 and mem_we=0, forced while rstz is low.
- Requests:
  - data_req = data_rd_req | data_wr_req.
  - If data_rd_req and data_wr_req are both high, the access is a write; one data_gnt is issued; no read is performed.
- IDLE:
  - No request: mem_en=0, stay in IDLE.
  - Only one master requesting: that master wins.
  - Both requesting: the master that is not last_owner wins.
  - On a win, in the same cycle (combinational):
    - mem_en=1.
    - mem_addr = winner_addr[MEM_AW+1:2].
    - mem_we=1 only for a data write. mem_wr_data=data_wr_data, mem_wr_mask=data_wr_mask.
  - Next state: RESP. owner and last_owner are both set to the winner.
- RESP:
  - mem_en=0.
  - Assert the gnt of owner for exactly this cycle.
  - instr_data = mem_rd_data (combinational passthrough). data_rd_data = mem_rd_data.
  - Write gnt also arrives in RESP; rd_data is don't-care for writes.
  - Next state: IDLE unconditionally.
- Latency: grant 1 cycle after strobe. Throughput: 1 access per 2 cycles. Back-to-back requests from the same master alternate IDLE/RESP.
- Fairness:
  - With both masters continuously requesting, accesses strictly alternate.
  - Neither master waits more than 4 cycles from request to gnt.
- Address bits [1:0] and bits above MEM_AW+1 are ignored (no misalignment or range check).
- Request dropped after strobe (e.g. IF flush on branch): the access has already been performed and gnt still pulses in RESP. The master must tolerate a stale gnt.
- Request dropped in IDLE before win: no access.
- Inputs are sampled only in IDLE. Address and data changes during RESP have no effect.
- mem_rd_data outside RESP is passed through to both rd_data outputs but carries no meaning without gnt.
- Reset asserted during RESP: gnt drops immediately (async); state returns to IDLE; the pending grant is lost.

Test Plan:
- Reset, then instr_req=1, instr_addr=0x0000_0010, with the SRAM model holding 0x0000_0013 at word 4 -> mem_en=1, mem_addr=4, mem_we=0 in cycle 0. In cycle 1: instr_gnt=1, instr_data=0x0000_0013, data_gnt=0.
- data_wr_req=1, addr=0x0000_0104, wr_data=0xDEADBEEF, mask=4'b0011, then data_rd_req to the same address -> write strobe has mem_addr=0x41, mem_we=1, mask=0011. The later read returns 0x????BEEF, i.e. the low half-word updated.
- Both requests held high for 8 cycles -> strobes in IDLE cycles alternate instr, data, instr, data (first tie goes to instr after reset). Gnts are one-cycle pulses, never both high together.
- instr_req dropped during RESP -> instr_gnt still pulses that cycle. The next cycle is IDLE with no strobe if no other request is pending.
- rstz pulled low in a RESP cycle for an instr read -> instr_gnt goes to 0 immediately and mem_en stays 0. After release, the re-held request is re-issued from IDLE.
- data_rd_req=1 and data_wr_req=1 together -> a single mem_we=1 strobe, then one data_gnt pulse.
